// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
// State encoding, response error codes and default parameter values.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_SLVERR   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_cmd_timeout.sv
// ACCESS-phase wait counter; saturates at TIMEOUT.
// Ports: clk, rst (sync, high), clr, inc -> expired.
module apb_cmd_timeout
  import apb_cmd_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Flags the cycle whose increment brings the count
  // to TIMEOUT, so the master leaves ACCESS on that
  // same edge and the bus sees exactly TIMEOUT waits.
  assign expired = inc && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding command to APB master with timeout.
// Ports: cmd_* in, rsp_* out, APB p* master side.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e            state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_err_q;

  logic accept;
  logic aligned;
  logic to_clr;
  logic to_inc;
  logic to_expired;

  // Gated by rst so the block refuses work while held.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign aligned   = (cmd_addr[1:0] == 2'b00);
  assign to_clr    = accept && aligned;
  assign to_inc    = (state_q == S_ACCESS) && !pready;

  apb_cmd_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .inc    (to_inc),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (aligned) begin
              paddr_q  <= cmd_addr;
              pwrite_q <= cmd_write;
              pwdata_q <= cmd_wdata;
              psel_q   <= 1'b1;
              state_q  <= S_SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_MISALIGN;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= pslverr ? ERR_SLVERR
                                   : ERR_OK;
            // Data only for a clean read.
            rsp_rdata_q <= (pwrite_q || pslverr)
                           ? '0 : prdata;
            state_q     <= S_RESP;
          end else if (to_expired) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_TIMEOUT;
            rsp_rdata_q <= '0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master.
// Random and directed commands against a slave model.
module tb_apb_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_cmd_master #(
    .ADDR_W (8),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
    int          nacc;
    int          nset;
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    int          hold;
    int          rsp_cyc;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          cur_wait = 0;
  bit          cur_err  = 1'b0;
  logic [31:0] cur_prd  = '0;
  int          acc_seen = 0;

  int          vcnt = 0;
  int          nacc = 0;
  int          nset = 0;
  bit          after_hs = 1'b0;
  logic [1:0]  s_err;
  logic [31:0] s_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Expected outcome from the command and slave behaviour.
  function automatic exp_t model(
    input bit wr, input logic [7:0] a,
    input logic [31:0] wd, input int wt,
    input bit se, input logic [31:0] prd,
    input int hold);
    exp_t e;
    e.addr  = a;
    e.wr    = wr;
    e.wdata = wd;
    e.hold  = hold;
    e.rdata = '0;
    e.rsp_cyc = 0;
    if (a[1:0] != 2'b00) begin
      e.err  = 2'b11;
      e.nset = 0;
      e.nacc = 0;
      e.lat  = 1;
    end else if (wt >= TO) begin
      e.err  = 2'b10;
      e.nset = 1;
      e.nacc = TO;
      e.lat  = 2 + TO;
    end else begin
      e.err  = se ? 2'b01 : 2'b00;
      e.nset = 1;
      e.nacc = wt + 1;
      e.lat  = 3 + wt;
      if (!se && !wr) e.rdata = prd;
    end
    return e;
  endfunction

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
  endtask

  task automatic issue(input bit wr,
                       input logic [7:0] a,
                       input logic [31:0] wd,
                       input int wt,
                       input bit se,
                       input logic [31:0] prd,
                       input int hold);
    exp_t e;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL accept_wait: cmd_ready 0 for 300 cycles");
      summary();
      $fatal(1, "accept wait expired");
    end
    e = model(wr, a, wd, wt, se, prd, hold);
    e.rsp_cyc = cyc + e.lat;
    sb.push_back(e);
    cur_wait = wt;
    cur_err  = se;
    cur_prd  = prd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  // APB slave: pready in access cycle number cur_wait.
  always @(negedge clk) begin
    if (psel && penable) begin
      pready = (acc_seen == cur_wait);
      acc_seen++;
    end else begin
      pready   = 1'b0;
      acc_seen = 0;
    end
    prdata  = cur_prd;
    pslverr = cur_err;
  end

  // Monitor: protocol, bus and response checks.
  always @(negedge clk) begin
    if (rst) begin
      vcnt      = 0;
      nacc      = 0;
      nset      = 0;
      after_hs  = 1'b0;
      rsp_ready = 1'b0;
    end else begin
      if (after_hs) begin
        chk_eq("ready_after_hs", 32'(cmd_ready), 32'd1);
        after_hs = 1'b0;
      end
      if (penable) chk_eq("penable_wo_psel", 32'(psel), 32'd1);
      if (psel) chk_eq("ready_busy", 32'(cmd_ready), 32'd0);
      if (psel && sb.size() > 0) begin
        chk_eq("paddr", 32'(paddr), 32'(sb[0].addr));
        chk_eq("pwrite", 32'(pwrite), 32'(sb[0].wr));
        if (penable) begin
          nacc++;
          if (sb[0].wr) chk_eq("pwdata", pwdata, sb[0].wdata);
        end else begin
          nset++;
        end
      end
      if (rsp_valid) begin
        chk_eq("psel_in_resp", 32'(psel), 32'd0);
        chk_eq("ready_in_resp", 32'(cmd_ready), 32'd0);
        if (sb.size() == 0) begin
          chk_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
          rsp_ready = 1'b1;
        end else begin
          if (vcnt == 0) begin
            chk_eq("latency", 32'(cyc), 32'(sb[0].rsp_cyc));
            s_err   = rsp_err;
            s_rdata = rsp_rdata;
          end else begin
            chk_eq("err_stable", 32'(rsp_err), 32'(s_err));
            chk_eq("rdata_stable", rsp_rdata, s_rdata);
          end
          vcnt++;
          rsp_ready = (vcnt > sb[0].hold);
          if (rsp_ready) begin
            chk_eq("rsp_err", 32'(rsp_err), 32'(sb[0].err));
            chk_eq("rsp_rdata", rsp_rdata, sb[0].rdata);
            chk_eq("n_access", 32'(nacc), 32'(sb[0].nacc));
            chk_eq("n_setup", 32'(nset), 32'(sb[0].nset));
            void'(sb.pop_front());
            vcnt     = 0;
            nacc     = 0;
            nset     = 0;
            after_hs = 1'b1;
          end
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_eq("rst_psel", 32'(psel), 32'd0);
    chk_eq("rst_penable", 32'(penable), 32'd0);
    chk_eq("rst_pwrite", 32'(pwrite), 32'd0);
    chk_eq("rst_paddr", 32'(paddr), 32'd0);
    chk_eq("rst_pwdata", pwdata, 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Directed cases.
    issue(1'b1, 8'h08, 32'h1, 0, 1'b0, 32'h0, 0);
    issue(1'b0, 8'h0C, 32'h0, 2, 1'b0,
          32'hDEADBEEF, 1);
    issue(1'b0, 8'h04, 32'h0, 1000, 1'b0,
          32'h55AA55AA, 1);
    issue(1'b1, 8'h06, 32'h77, 0, 1'b0, 32'h0, 0);
    issue(1'b0, 8'h00, 32'h0, 0, 1'b1,
          32'h12345678, 5);
    issue(1'b1, 8'h20, 32'hCAFE0001, 0, 1'b0,
          32'h0, 0);
    issue(1'b0, 8'h10, 32'h0, TO - 1, 1'b0,
          32'hA5A5F00D, 0);
    issue(1'b0, 8'h14, 32'h0, TO, 1'b0,
          32'hA5A5F00D, 2);
    issue(1'b1, 8'h18, 32'hBEEF, 3, 1'b1,
          32'h0, 0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      int wt;
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 9))
        0:       wt = TO;
        1:       wt = TO - 1;
        2:       wt = TO + 3;
        default: wt = int'($urandom_range(0, 4));
      endcase
      issue(1'($urandom), a, $urandom, wt,
            ($urandom_range(0, 3) == 0), $urandom,
            int'($urandom_range(0, 3)));
    end
    drain();

    // Reset in the second ACCESS cycle abandons the read.
    @(negedge clk);
    cur_wait  = 1000;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h24;
    chk_eq("rt_idle_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_eq("rt_setup_psel", 32'(psel), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk_eq("rt_access2", 32'(psel && penable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("rt_psel", 32'(psel), 32'd0);
    chk_eq("rt_penable", 32'(penable), 32'd0);
    chk_eq("rt_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rt_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rt_ready_after", 32'(cmd_ready), 32'd1);
    chk_eq("rt_no_rsp", 32'(rsp_valid), 32'd0);

    // Normal service resumes.
    issue(1'b0, 8'h2C, 32'h0, 1, 1'b0,
          32'h0BADF00D, 0);
    drain();

    summary();
    $finish;
  end

endmodule
